// File: rtl/serial_bit_tx_if.sv
// serial_bit_tx_if: word handshake in, serial d/en stream and status out
interface serial_bit_tx_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             d;
    logic             en;
    logic             busy;
    logic             done;
    modport master (output in_valid, in_data, input in_ready, d, en, busy, done);
    modport slave (input in_valid, in_data, output in_ready, d, en, busy, done);
endinterface

// File: rtl/serial_bit_tx.sv
// serial_bit_tx: accepts a word on valid/ready and shifts it out one bit per BIT_CYCLES clocks
module serial_bit_tx #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 1,
    parameter int LSB_FIRST  = 1
) (
    input logic            clk,
    input logic            rst,
    serial_bit_tx_if.slave bus
);
    localparam int BW = $clog2(WIDTH);
    localparam int CW = $clog2(BIT_CYCLES) + 1;
    localparam logic [BW-1:0] bit_last = BW'(WIDTH - 1);
    localparam logic [CW-1:0] cyc_last = CW'(BIT_CYCLES - 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] sr, sr_n, src;
    logic [BW-1:0] bit_cnt, bit_n;
    logic [CW-1:0] cyc_cnt, cyc_n;
    logic ready_q, d_q, en_q, busy_q, done_q;
    logic ready_n, d_n, en_n, busy_n, done_n;
    logic take, last_cyc;
    assign take     = state == IDLE && bus.in_valid && ready_q;
    assign last_cyc = cyc_cnt == cyc_last;
    assign src      = state == IDLE ? bus.in_data : sr;
    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            bit_cnt <= '0;
            cyc_cnt <= '0;
            ready_q <= 1'b1;
            d_q     <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            sr      <= sr_n;
            bit_cnt <= bit_n;
            cyc_cnt <= cyc_n;
            ready_q <= ready_n;
            d_q     <= d_n;
            en_q    <= en_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end
    // next state: load on handshake, hold each bit, advance or finish on the last cycle of a bit
    always_comb begin
        state_n = state;
        sr_n    = sr;
        bit_n   = bit_cnt;
        cyc_n   = cyc_cnt;
        ready_n = state == IDLE && !take;
        d_n     = 1'b0;
        en_n    = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        if (take || (state == SHIFT && last_cyc && bit_cnt != bit_last)) begin
            state_n = SHIFT;
            d_n     = LSB_FIRST != 0 ? src[0] : src[WIDTH-1];
            sr_n    = LSB_FIRST != 0 ? src >> 1 : src << 1;
            bit_n   = take ? '0 : bit_cnt + 1'b1;
            cyc_n   = '0;
            en_n    = 1'b1;
            busy_n  = 1'b1;
        end else if (state == SHIFT && last_cyc) begin
            state_n = IDLE;
            sr_n    = '0;
            bit_n   = '0;
            cyc_n   = '0;
            ready_n = 1'b1;
            done_n  = 1'b1;
        end else if (state == SHIFT) begin
            cyc_n   = cyc_cnt + 1'b1;
            d_n     = d_q;
            busy_n  = 1'b1;
        end
    end
    assign bus.in_ready = ready_q;
    assign bus.d        = d_q;
    assign bus.en       = en_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_serial_bit_tx.sv
// tb_serial_bit_tx: checks two configurations against a timeline model plus directed literal streams
module tb_serial_bit_tx;
    logic clk, rst, in_valid;
    logic [7:0] in_data;
    int checks = 0;
    int errors = 0;
    serial_bit_tx_if #(.WIDTH(8)) if0 ();
    serial_bit_tx_if #(.WIDTH(8)) if1 ();
    assign if0.in_valid = in_valid;
    assign if0.in_data  = in_data;
    assign if1.in_valid = in_valid;
    assign if1.in_data  = in_data;
    serial_bit_tx #(.WIDTH(8), .BIT_CYCLES(1), .LSB_FIRST(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    serial_bit_tx #(.WIDTH(8), .BIT_CYCLES(3), .LSB_FIRST(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    logic [4:0] o [2];
    assign o[0] = {if0.in_ready, if0.d, if0.en, if0.busy, if0.done};
    assign o[1] = {if1.in_ready, if1.d, if1.en, if1.busy, if1.done};
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask
    // model: each accepted word occupies edges st..st+8*B-1, then one done cycle
    int bc [2] = '{1, 3};
    bit lf [2] = '{1'b1, 1'b0};
    logic [4:0] xo [2];
    logic act [2] = '{1'b0, 1'b0};
    int st [2] = '{0, 0};
    logic [7:0] wd [2];
    int e = 0;
    bit mv = 0;
    always @(posedge clk) begin
        e++;
        for (int i = 0; i < 2; i++) begin
            int t;
            if (rst) begin
                act[i] = 1'b0;
                mv = 1;
            end else if (!act[i] && xo[i][4] === 1'b1 && in_valid) begin
                act[i] = 1'b1;
                st[i] = e;
                wd[i] = in_data;
            end
            t = e - st[i];
            if (act[i] && t < 8 * bc[i])
                xo[i] = {1'b0, wd[i][lf[i] ? t / bc[i] : 7 - t / bc[i]], t % bc[i] == 0, 1'b1, 1'b0};
            else if (act[i]) begin
                act[i] = 1'b0;
                xo[i] = 5'b10001;
            end else
                xo[i] = 5'b10000;
        end
        #1;
        if (mv)
            for (int i = 0; i < 2; i++)
                chk($sformatf("cycle%0d_dut%0d", e, i), int'(o[i]), int'(xo[i]));
    end
    initial begin
        int n, dn, di, bz;
        logic dz;
        logic [7:0] b0, mb;
        logic [15:0] b16;
        logic [17:0] pat;
        logic [23:0] v24;
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_dut0", int'(o[0]), 'h10);
        chk("reset_dut1", int'(o[1]), 'h10);
        chk("reset_model", int'(xo[0]), 'h10);
        rst = 1'b0;
        in_valid = 1'b0;
        n = 0;
        dz = 1'b0;
        repeat (20) begin
            @(negedge clk);
            n += int'(o[0][2]) + int'(o[1][2]);
            dz |= o[0][3] | o[1][3];
        end
        chk("idle_en_count", n, 0);
        chk("idle_d", int'(dz), 0);
        in_valid = 1'b1;
        in_data = 8'hA5;
        n = 0; dn = 0; di = -1; b0 = '0; mb = '0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data = 8'h00;
            if (o[0][2]) begin n++; b0 = {b0[6:0], o[0][3]}; end
            if (xo[0][2]) mb = {mb[6:0], xo[0][3]};
            if (o[0][0]) begin dn++; di = k; end
        end
        chk("a5_bits", int'(b0), 'hA5);
        chk("a5_model_bits", int'(mb), 'hA5);
        chk("a5_en_count", n, 8);
        chk("a5_done_count", dn, 1);
        chk("a5_done_cycle", di, 8);
        in_valid = 1'b1;
        in_data = 8'h81;
        n = 0; bz = 0; di = -1; v24 = '0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data = 8'h00;
            n += int'(o[1][2]);
            if (o[1][1]) begin bz++; v24 = {v24[22:0], o[1][3]}; end
            if (o[1][0]) di = k;
        end
        chk("h81_d_runs", int'(v24), 'hE00007);
        chk("h81_busy_cycles", bz, 24);
        chk("h81_en_count", n, 8);
        chk("h81_done_cycle", di, 24);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hF0;
        pat = '0; b16 = '0; dn = 0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            pat = {pat[16:0], o[0][2]};
            if (o[0][2]) b16 = {b16[14:0], o[0][3]};
            dn += int'(o[0][0]);
            if (k == 1) in_data = 8'h33;
            if (k == 5) in_data = 8'h0F;
            if (k == 10) in_valid = 1'b0;
        end
        chk("b2b_en_pattern", int'(pat), 'h3FDFE);
        chk("b2b_bits", int'(b16), 'h0FF0);
        chk("b2b_done_count", dn, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hFF;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", int'(o[0]), 'h10);
        rst = 1'b0;
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            dn += int'(o[0][0]);
        end
        chk("midreset_no_done", dn, 0);
        in_valid = 1'b1;
        in_data = 8'h01;
        b0 = '0; dn = 0;
        repeat (12) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (o[0][2]) b0 = {b0[6:0], o[0][3]};
            dn += int'(o[0][0]);
        end
        chk("after_reset_bits", int'(b0), 'h80);
        chk("after_reset_done", dn, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
